// File: rtl/exec_sequencer_if.sv
// Bundle of signals between the instruction decoder / execution units and the
// issue/retire sequencer.
//   master : decoder side; drives the instruction fields, unit_done, flush and
//            err_clr, and observes the sequencer outputs.
//   slave  : sequencer side.
// Signals: instr_valid/instr_ready handshake, opr_typ_sel, src_dst_delay_sel,
//          src_dst_delay, alu_o_sel, alu_t_sel, prng_t_sel, unit_done, flush,
//          err_clr, alu_start, prng_start, wb_en, retire_opr, fetch_stall,
//          timeout_err, retire_cnt.
interface exec_sequencer_if #(
  parameter int OPR_W = 5,
  parameter int DLY_W = 8,
  parameter int RC_W  = 16
);
  logic             instr_valid;
  logic             instr_ready;
  logic [OPR_W-1:0] opr_typ_sel;
  logic             src_dst_delay_sel;
  logic [DLY_W-1:0] src_dst_delay;
  logic             alu_o_sel;
  logic             alu_t_sel;
  logic             prng_t_sel;
  logic             unit_done;
  logic             flush;
  logic             err_clr;
  logic             alu_start;
  logic             prng_start;
  logic             wb_en;
  logic [OPR_W-1:0] retire_opr;
  logic             fetch_stall;
  logic             timeout_err;
  logic [RC_W-1:0]  retire_cnt;

  modport master (
    output instr_valid, opr_typ_sel, src_dst_delay_sel, src_dst_delay,
           alu_o_sel, alu_t_sel, prng_t_sel, unit_done, flush, err_clr,
    input  instr_ready, alu_start, prng_start, wb_en, retire_opr,
           fetch_stall, timeout_err, retire_cnt
  );

  modport slave (
    input  instr_valid, opr_typ_sel, src_dst_delay_sel, src_dst_delay,
           alu_o_sel, alu_t_sel, prng_t_sel, unit_done, flush, err_clr,
    output instr_ready, alu_start, prng_start, wb_en, retire_opr,
           fetch_stall, timeout_err, retire_cnt
  );
endinterface

// File: rtl/exec_sequencer.sv
// Issue/retire controller between the instruction decoder and the execution
// units. Accepts one instruction at a time, fires start pulses to the selected
// unit, holds the pipeline for a fixed latency or until the unit reports done
// (guarded by a watchdog), then emits a one-cycle writeback/retire pulse.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : exec_sequencer_if.slave (instruction handshake, unit handshake,
//          flush/err_clr controls, start/retire pulses, status, retire count)
module exec_sequencer #(
  parameter int OPR_W     = 5,
  parameter int DLY_W     = 8,
  parameter int WAIT_CODE = 255,
  parameter int TO_W      = 12,
  parameter int TIMEOUT   = 4000,
  parameter int RC_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  exec_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_COUNT,
    S_WAIT_DONE,
    S_RETIRE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [OPR_W-1:0] r_opr;
  logic [DLY_W-1:0] r_dly;
  logic             r_start_alu;
  logic             r_start_prng;
  logic [DLY_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_wd;
  logic             r_timeout_err;
  logic [RC_W-1:0]  r_retire_cnt;

  logic w_ready;
  logic w_accept;
  logic w_wd_expire;
  logic w_timeout;
  logic w_retire;

  assign w_ready     = (r_state == S_IDLE) && !bus.flush;
  assign w_accept    = bus.instr_valid && w_ready;
  assign w_wd_expire = (r_wd == TO_W'(TIMEOUT - 1));
  // Expiry only counts when neither a done pulse (done wins) nor a flush
  // (instruction abandoned) lands in the same cycle.
  assign w_timeout   = (r_state == S_WAIT_DONE) && w_wd_expire &&
                       !bus.unit_done && !bus.flush;
  // A flush during the retire cycle abandons the writeback as well.
  assign w_retire    = (r_state == S_RETIRE) && !bus.flush;

  // NOTE: w_next gets its default before the case so every path assigns it;
  // a missing branch would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_next = bus.src_dst_delay_sel ? S_ISSUE : S_RETIRE;
      S_ISSUE: begin
        if (r_dly == DLY_W'(WAIT_CODE))
          w_next = bus.unit_done ? S_RETIRE : S_WAIT_DONE;
        else if (r_dly <= DLY_W'(1))
          w_next = S_RETIRE;
        else
          w_next = S_COUNT;
      end
      S_COUNT:     if (r_cnt == DLY_W'(1)) w_next = S_RETIRE;
      S_WAIT_DONE: if (bus.unit_done || w_wd_expire) w_next = S_RETIRE;
      S_RETIRE:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    if (bus.flush && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath registers are reset too, so retire_opr and the counters start
  // from a known value rather than X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opr         <= '0;
      r_dly         <= '0;
      r_start_alu   <= 1'b0;
      r_start_prng  <= 1'b0;
      r_cnt         <= '0;
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
      r_retire_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_opr        <= bus.opr_typ_sel;
        r_dly        <= bus.src_dst_delay;
        r_start_alu  <= bus.alu_o_sel & bus.alu_t_sel;
        r_start_prng <= bus.prng_t_sel;
      end

      // ISSUE already consumed one cycle of the latency, so COUNT starts at
      // delay-1 and hands over to RETIRE when it reaches 1.
      if (r_state == S_ISSUE)
        r_cnt <= r_dly - DLY_W'(1);
      else if (r_state == S_COUNT)
        r_cnt <= r_cnt - DLY_W'(1);

      // Watchdog runs only while parked in WAIT_DONE; any exit clears it.
      if ((r_state == S_WAIT_DONE) && (w_next == S_WAIT_DONE))
        r_wd <= r_wd + TO_W'(1);
      else
        r_wd <= '0;

      // Set has priority over clear.
      if (w_timeout)
        r_timeout_err <= 1'b1;
      else if (bus.err_clr)
        r_timeout_err <= 1'b0;

      if (w_retire)
        r_retire_cnt <= r_retire_cnt + RC_W'(1);
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.alu_start   = (r_state == S_ISSUE) && r_start_alu;
  assign bus.prng_start  = (r_state == S_ISSUE) && r_start_prng;
  assign bus.wb_en       = w_retire;
  assign bus.retire_opr  = r_opr;
  assign bus.fetch_stall = (r_state != S_IDLE);
  assign bus.timeout_err = r_timeout_err;
  assign bus.retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer. Each instruction's expected timeline
// (start pulse cycle, retire cycle, flush abort, watchdog expiry) is computed
// arithmetically from the latency rules and compared cycle by cycle.
module tb_exec_sequencer;

  localparam int OPR_W     = 5;
  localparam int DLY_W     = 8;
  localparam int WAIT_CODE = 255;
  localparam int TO_W      = 12;
  localparam int TIMEOUT   = 4000;
  localparam int RC_W      = 8;
  localparam int RC_MOD    = 1 << RC_W;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_cnt;
  logic exp_err;

  exec_sequencer_if #(.OPR_W(OPR_W), .DLY_W(DLY_W), .RC_W(RC_W)) bus ();

  exec_sequencer #(
    .OPR_W(OPR_W), .DLY_W(DLY_W), .WAIT_CODE(WAIT_CODE),
    .TO_W(TO_W), .TIMEOUT(TIMEOUT), .RC_W(RC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.instr_valid       = 1'b0;
    bus.opr_typ_sel       = '0;
    bus.src_dst_delay_sel = 1'b0;
    bus.src_dst_delay     = '0;
    bus.alu_o_sel         = 1'b0;
    bus.alu_t_sel         = 1'b0;
    bus.prng_t_sel        = 1'b0;
    bus.unit_done         = 1'b0;
    bus.flush             = 1'b0;
    bus.err_clr           = 1'b0;
  endtask

  // Issue one instruction at cycle 0 and follow it to completion.
  // d     : cycle (relative to accept) carrying a unit_done pulse, -1 = none
  // f     : cycle carrying flush, -1 = none
  // clr_k : cycle carrying err_clr, -1 = none
  // done0 : unit_done level during the accept cycle (must be ignored in IDLE)
  task automatic run_instr(input logic [OPR_W-1:0] opr, input logic sel,
                           input int dly, input logic ao, input logic at,
                           input logic pt, input int d, input int f,
                           input int clr_k, input logic done0);
    int   wb_k;
    int   end_k;
    logic to_hit;
    logic flushed;
    to_hit = 1'b0;
    if (!sel)                           wb_k = 1;
    else if (dly != WAIT_CODE)          wb_k = 1 + ((dly > 1) ? dly : 1);
    else if (d >= 1 && d <= TIMEOUT+1)  wb_k = d + 1;
    else begin
      wb_k   = TIMEOUT + 2;
      to_hit = 1'b1;
    end
    flushed = (f >= 1) && (f <= wb_k);
    end_k   = flushed ? f : wb_k;

    @(negedge clk);
    check("pre_stall", bus.fetch_stall, 1'b0);
    bus.instr_valid       = 1'b1;
    bus.opr_typ_sel       = opr;
    bus.src_dst_delay_sel = sel;
    bus.src_dst_delay     = DLY_W'(dly);
    bus.alu_o_sel         = ao;
    bus.alu_t_sel         = at;
    bus.prng_t_sel        = pt;
    bus.unit_done         = done0;
    bus.flush             = 1'b0;
    bus.err_clr           = 1'b0;
    #1;
    check("accept_ready", bus.instr_ready, 1'b1);

    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.unit_done   = (k == d);
      bus.flush       = (k == f);
      bus.err_clr     = (k == clr_k);
      #1;
      check("stall",      bus.fetch_stall, 1'b1);
      check("ready_busy", bus.instr_ready, 1'b0);
      check("alu_start",  bus.alu_start,  (k == 1) && sel && ao && at);
      check("prng_start", bus.prng_start, (k == 1) && sel && pt);
      check("wb_en",      bus.wb_en,      (k == wb_k) && !flushed);
      check("timeout_err", bus.timeout_err, exp_err);
      if (k == wb_k && !flushed) check("retire_opr", bus.retire_opr, opr);
      if (to_hit && k == TIMEOUT + 1 && !(f >= 1 && f <= k)) exp_err = 1'b1;
      else if (k == clr_k)                                    exp_err = 1'b0;
    end
    if (!flushed) exp_cnt = (exp_cnt + 1) % RC_MOD;

    @(negedge clk);
    idle_inputs();
    #1;
    check("post_stall",  bus.fetch_stall, 1'b0);
    check("post_ready",  bus.instr_ready, 1'b1);
    check("post_wb",     bus.wb_en, 1'b0);
    check("retire_cnt",  bus.retire_cnt, RC_W'(exp_cnt));
    check("post_err",    bus.timeout_err, exp_err);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 0;
    exp_err = 1'b0;
    idle_inputs();
    rst = 1'b1;
    #12;
    check("rst_ready",   bus.instr_ready, 1'b1);
    check("rst_stall",   bus.fetch_stall, 1'b0);
    check("rst_wb",      bus.wb_en, 1'b0);
    check("rst_alu",     bus.alu_start, 1'b0);
    check("rst_prng",    bus.prng_start, 1'b0);
    check("rst_err",     bus.timeout_err, 1'b0);
    check("rst_cnt",     bus.retire_cnt, '0);
    @(negedge clk);
    rst = 1'b0;

    // ADD: fixed latency 4, ALU start
    run_instr(5'd2, 1'b1, 4, 1'b1, 1'b1, 1'b0, -1, -1, -1, 1'b0);
    // MUL: wait-for-done, done at +40
    run_instr(5'd3, 1'b1, WAIT_CODE, 1'b1, 1'b1, 1'b0, 40, -1, -1, 1'b0);
    // wait-for-done, done coincident with ISSUE
    run_instr(5'd4, 1'b1, WAIT_CODE, 1'b0, 1'b0, 1'b1, 1, -1, -1, 1'b0);
    // watchdog expiry
    run_instr(5'd5, 1'b1, WAIT_CODE, 1'b1, 1'b1, 1'b0, -1, -1, -1, 1'b0);
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    exp_err = 1'b0;
    #1;
    check("err_cleared", bus.timeout_err, 1'b0);
    // expiry with err_clr in the same cycle: set wins
    run_instr(5'd6, 1'b1, WAIT_CODE, 1'b0, 1'b0, 1'b0, -1, -1, TIMEOUT + 1, 1'b0);
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    exp_err = 1'b0;
    #1;
    check("err_cleared2", bus.timeout_err, 1'b0);
    // done coincident with the expiry cycle: done wins, no error
    run_instr(5'd7, 1'b1, WAIT_CODE, 1'b0, 1'b0, 1'b0, TIMEOUT + 1, -1, -1, 1'b0);
    // MOV without timed phase, then delay 0, then delay 1
    run_instr(5'd8,  1'b0, 7, 1'b1, 1'b1, 1'b1, -1, -1, -1, 1'b0);
    run_instr(5'd9,  1'b1, 0, 1'b0, 1'b0, 1'b0, -1, -1, -1, 1'b0);
    run_instr(5'd10, 1'b1, 1, 1'b0, 1'b0, 1'b0, -1, -1, -1, 1'b0);
    // PRNG seed flushed in COUNT
    run_instr(5'd11, 1'b1, 3, 1'b0, 1'b0, 1'b1, -1, 2, -1, 1'b0);
    // flush in ISSUE keeps the start pulse
    run_instr(5'd12, 1'b1, 6, 1'b1, 1'b1, 1'b0, -1, 1, -1, 1'b0);
    // flush in RETIRE suppresses writeback
    run_instr(5'd13, 1'b1, 2, 1'b0, 1'b0, 1'b0, -1, 3, -1, 1'b0);
    // unit_done ignored in COUNT and in IDLE
    run_instr(5'd14, 1'b1, 6, 1'b1, 1'b1, 1'b0, 3, -1, -1, 1'b1);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    bus.instr_valid       = 1'b1;
    bus.src_dst_delay_sel = 1'b1;
    bus.src_dst_delay     = 8'd4;
    bus.flush             = 1'b1;
    #1;
    check("flush_idle_ready", bus.instr_ready, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("flush_idle_stall", bus.fetch_stall, 1'b0);

    // randomized instructions
    for (int n = 0; n < 60; n++) begin
      int   dly;
      int   f;
      logic sel;
      dly = ($urandom_range(0, 4) == 0) ? WAIT_CODE : int'($urandom_range(0, 12));
      f   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 14)) : -1;
      sel = ($urandom_range(0, 5) != 0);
      run_instr(OPR_W'($urandom), sel, dly, 1'($urandom), 1'($urandom),
                1'($urandom), int'($urandom_range(1, 50)), f, -1, 1'($urandom));
    end

    // back-to-back delay-1 ops with valid held high; crosses the counter wrap
    @(negedge clk);
    bus.instr_valid       = 1'b1;
    bus.src_dst_delay_sel = 1'b1;
    bus.src_dst_delay     = 8'd1;
    for (int i = 1; i <= 900; i++) begin
      @(negedge clk);
      #1;
      check("b2b_wb", bus.wb_en, (i % 3) == 2);
      if (i == 900) bus.instr_valid = 1'b0;
    end
    exp_cnt = (exp_cnt + 300) % RC_MOD;
    @(negedge clk);
    #1;
    check("b2b_stall", bus.fetch_stall, 1'b0);
    check("b2b_cnt",   bus.retire_cnt, RC_W'(exp_cnt));
    idle_inputs();

    // asynchronous reset in the middle of COUNT
    @(negedge clk);
    bus.instr_valid       = 1'b1;
    bus.src_dst_delay_sel = 1'b1;
    bus.src_dst_delay     = 8'd20;
    bus.alu_o_sel         = 1'b1;
    bus.alu_t_sel         = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check("pre_rst_stall", bus.fetch_stall, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_stall", bus.fetch_stall, 1'b0);
    check("mid_rst_wb",    bus.wb_en, 1'b0);
    check("mid_rst_ready", bus.instr_ready, 1'b1);
    check("mid_rst_cnt",   bus.retire_cnt, '0);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    exp_err = 1'b0;
    run_instr(5'd21, 1'b1, 5, 1'b1, 1'b1, 1'b1, -1, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
